mem_access_stage: RTL and testbench

Memory-access pipeline stage that sits between EX/MEM and the writeback source mux. It accepts one instruction per cycle from EX. Loads and stores go through a single-outstanding request/response handshake to data memory, and the upstream pipeline is stalled while a memory access is outstanding. The stage registers the PC, ALU result, memory read data and writeback control into the MEM/WB boundary consumed by the writeback mux.

---
 rtl/mips_pkg.sv | 23 ++
 rtl/mem_wb_reg.sv | 52 +++++
 rtl/mem_access_stage.sv | 170 +++++++++++++++++
 tb/tb_mem_access_stage.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// mips_pkg
//   Shared types for the memory-access stage and its MEM/WB boundary register.
//   mem_state_t : access FSM states (idle / request outstanding).
//   JUMP_*      : jump class encodings carried to writeback.
//   wb_ctrl_t   : writeback control bundle (jump, memtoreg, regwrite, write_num).
package mips_pkg;

    typedef enum logic {
        MEM_IDLE   = 1'b0,
        MEM_ACCESS = 1'b1
    } mem_state_t;

    localparam logic [1:0] JUMP_NONE = 2'b00;
    localparam logic [1:0] JUMP_JAL  = 2'b10;

    typedef struct packed {
        logic [1:0] jump;
        logic       memtoreg;
        logic       regwrite;
        logic [4:0] write_num;
    } wb_ctrl_t;

endpackage

// File: rtl/mem_wb_reg.sv
// mem_wb_reg
//   MEM/WB boundary register feeding the writeback source mux.
//   Ports:
//     clk, rst_n         clock, async active-low reset (clears everything)
//     load               capture d_* and mark the slot valid
//     bubble             clear valid and regwrite, other fields hold
//     d_pc/d_alu/d_mem   PC, ALU result, load data to capture
//     d_ctrl             writeback control bundle to capture
//     q_valid, q_pc, q_alu, q_mem, q_ctrl  registered outputs
//   load has priority over bubble.
module mem_wb_reg
    import mips_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic          bubble,
    input  logic [31:0]   d_pc,
    input  logic [DW-1:0] d_alu,
    input  logic [DW-1:0] d_mem,
    input  wb_ctrl_t      d_ctrl,
    output logic          q_valid,
    output logic [31:0]   q_pc,
    output logic [DW-1:0] q_alu,
    output logic [DW-1:0] q_mem,
    output wb_ctrl_t      q_ctrl
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_valid <= 1'b0;
            q_pc    <= '0;
            q_alu   <= '0;
            q_mem   <= '0;
            q_ctrl  <= '0;
        end else if (load) begin
            q_valid <= 1'b1;
            q_pc    <= d_pc;
            q_alu   <= d_alu;
            q_mem   <= d_mem;
            q_ctrl  <= d_ctrl;
        end else if (bubble) begin
            // A bubble must never write the register file, so regwrite is
            // cleared along with valid; the data fields are left as they were.
            q_valid         <= 1'b0;
            q_ctrl.regwrite <= 1'b0;
        end
    end

endmodule

// File: rtl/mem_access_stage.sv
// mem_access_stage
//   Memory-access pipeline stage between EX/MEM and the writeback mux.
//   Ports:
//     clk, rst_n            clock, async active-low reset
//     ex_*                  instruction from EX/MEM (valid, pc, alu, store data,
//                           jump class, memtoreg, memwrite, regwrite, dest reg)
//     mem_stall             upstream must hold EX/MEM contents
//     dm_req/we/addr/wdata  data-memory request (from hold registers)
//     dm_rvalid/dm_rdata    data-memory response / ack and load data
//     wb_*                  MEM/WB boundary outputs to the writeback mux
//
//   Memory handshake: one request outstanding at a time. dm_req rises the
//   cycle after a load/store is accepted and stays high, with dm_we, dm_addr
//   and dm_wdata stable, until the cycle in which dm_rvalid is seen; that
//   cycle completes the transfer and dm_req drops on the next edge. dm_rvalid
//   outside an outstanding request is ignored. Upstream sees mem_stall high
//   for every cycle dm_req is high, including the response cycle.
module mem_access_stage
    import mips_pkg::*;
#(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          ex_valid,
    input  logic [31:0]   ex_pc,
    input  logic [DW-1:0] ex_alu,
    input  logic [DW-1:0] ex_store_data,
    input  logic [1:0]    ex_jump,
    input  logic          ex_memtoreg,
    input  logic          ex_memwrite,
    input  logic          ex_regwrite,
    input  logic [4:0]    ex_write_num,
    output logic          mem_stall,
    output logic          dm_req,
    output logic          dm_we,
    output logic [AW-1:0] dm_addr,
    output logic [DW-1:0] dm_wdata,
    input  logic          dm_rvalid,
    input  logic [DW-1:0] dm_rdata,
    output logic          wb_valid,
    output logic [31:0]   wb_pc,
    output logic [DW-1:0] wb_alu,
    output logic [DW-1:0] wb_mem,
    output logic [1:0]    wb_jump,
    output logic          wb_memtoreg,
    output logic          wb_regwrite,
    output logic [4:0]    wb_write_num
);

    mem_state_t state, next_state;

    // Hold registers: the accepted load/store, kept stable during ACCESS.
    logic [31:0]   hold_pc;
    logic [DW-1:0] hold_alu;
    logic [DW-1:0] hold_wdata;
    logic          hold_we;
    wb_ctrl_t      hold_ctrl;

    logic          mem_op;
    logic          hold_is_load;
    logic          latch_hold;
    logic          wb_load;
    logic          wb_bubble;
    logic [31:0]   d_pc;
    logic [DW-1:0] d_alu;
    logic [DW-1:0] d_mem;
    wb_ctrl_t      d_ctrl;
    wb_ctrl_t      ex_ctrl;
    wb_ctrl_t      q_ctrl;

    assign mem_op  = ex_valid & (ex_memtoreg | ex_memwrite);
    assign ex_ctrl = '{jump: ex_jump, memtoreg: ex_memtoreg,
                       regwrite: ex_regwrite, write_num: ex_write_num};

    // With both flags set the op is a store, so no load data is returned.
    assign hold_is_load = hold_ctrl.memtoreg & ~hold_we;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= MEM_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        latch_hold = 1'b0;
        wb_load    = 1'b0;
        wb_bubble  = 1'b0;
        d_pc       = ex_pc;
        d_alu      = ex_alu;
        d_mem      = '0;
        d_ctrl     = ex_ctrl;
        case (state)
            MEM_IDLE: begin
                if (mem_op) begin
                    latch_hold = 1'b1;
                    wb_bubble  = 1'b1;
                    next_state = MEM_ACCESS;
                end else if (ex_valid) begin
                    wb_load = 1'b1;
                end else begin
                    wb_bubble = 1'b1;
                end
            end
            MEM_ACCESS: begin
                if (dm_rvalid) begin
                    wb_load    = 1'b1;
                    d_pc       = hold_pc;
                    d_alu      = hold_alu;
                    d_mem      = hold_is_load ? dm_rdata : '0;
                    d_ctrl     = hold_ctrl;
                    next_state = MEM_IDLE;
                end else begin
                    wb_bubble = 1'b1;
                end
            end
            default: next_state = MEM_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_pc    <= '0;
            hold_alu   <= '0;
            hold_wdata <= '0;
            hold_we    <= 1'b0;
            hold_ctrl  <= '0;
        end else if (latch_hold) begin
            hold_pc    <= ex_pc;
            hold_alu   <= ex_alu;
            hold_wdata <= ex_store_data;
            hold_we    <= ex_memwrite;
            hold_ctrl  <= ex_ctrl;
        end
    end

    // Both decode straight from the state register, so there is no
    // combinational path from ex_* to the stall.
    assign mem_stall = (state == MEM_ACCESS);
    assign dm_req    = (state == MEM_ACCESS);
    assign dm_we     = hold_we;
    assign dm_addr   = hold_alu[AW-1:0];
    assign dm_wdata  = hold_wdata;

    mem_wb_reg #(.DW(DW)) u_mem_wb_reg (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (wb_load),
        .bubble  (wb_bubble),
        .d_pc    (d_pc),
        .d_alu   (d_alu),
        .d_mem   (d_mem),
        .d_ctrl  (d_ctrl),
        .q_valid (wb_valid),
        .q_pc    (wb_pc),
        .q_alu   (wb_alu),
        .q_mem   (wb_mem),
        .q_ctrl  (q_ctrl)
    );

    assign wb_jump      = q_ctrl.jump;
    assign wb_memtoreg  = q_ctrl.memtoreg;
    assign wb_regwrite  = q_ctrl.regwrite;
    assign wb_write_num = q_ctrl.write_num;

endmodule

// File: tb/tb_mem_access_stage.sv
module tb_mem_access_stage;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int EXP_W = 32 + DW + 2 + DW;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          ex_valid;
    logic [31:0]   ex_pc;
    logic [DW-1:0] ex_alu;
    logic [DW-1:0] ex_store_data;
    logic [1:0]    ex_jump;
    logic          ex_memtoreg;
    logic          ex_memwrite;
    logic          ex_regwrite;
    logic [4:0]    ex_write_num;
    logic          mem_stall;
    logic          dm_req;
    logic          dm_we;
    logic [AW-1:0] dm_addr;
    logic [DW-1:0] dm_wdata;
    logic          dm_rvalid;
    logic [DW-1:0] dm_rdata = '0;
    logic          wb_valid;
    logic [31:0]   wb_pc;
    logic [DW-1:0] wb_alu;
    logic [DW-1:0] wb_mem;
    logic [1:0]    wb_jump;
    logic          wb_memtoreg;
    logic          wb_regwrite;
    logic [4:0]    wb_write_num;

    // memory responder controls
    logic          resp_en = 1'b0;
    logic          resp_rvalid = 1'b0;
    logic          spur_rvalid = 1'b0;
    int            mem_wait = 0;
    logic [DW-1:0] mem_rdata = '0;
    int            wcnt = 0;

    // scoreboard
    logic [EXP_W-1:0] exp_q[$];
    logic             mon_en = 1'b0;

    int n_checks = 0;
    int n_pass   = 0;

    assign dm_rvalid = resp_rvalid | spur_rvalid;

    mem_access_stage #(.AW(AW), .DW(DW)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .ex_valid      (ex_valid),
        .ex_pc         (ex_pc),
        .ex_alu        (ex_alu),
        .ex_store_data (ex_store_data),
        .ex_jump       (ex_jump),
        .ex_memtoreg   (ex_memtoreg),
        .ex_memwrite   (ex_memwrite),
        .ex_regwrite   (ex_regwrite),
        .ex_write_num  (ex_write_num),
        .mem_stall     (mem_stall),
        .dm_req        (dm_req),
        .dm_we         (dm_we),
        .dm_addr       (dm_addr),
        .dm_wdata      (dm_wdata),
        .dm_rvalid     (dm_rvalid),
        .dm_rdata      (dm_rdata),
        .wb_valid      (wb_valid),
        .wb_pc         (wb_pc),
        .wb_alu        (wb_alu),
        .wb_mem        (wb_mem),
        .wb_jump       (wb_jump),
        .wb_memtoreg   (wb_memtoreg),
        .wb_regwrite   (wb_regwrite),
        .wb_write_num  (wb_write_num)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive_idle();
        ex_valid      = 1'b0;
        ex_pc         = '0;
        ex_alu        = '0;
        ex_store_data = '0;
        ex_jump       = 2'b00;
        ex_memtoreg   = 1'b0;
        ex_memwrite   = 1'b0;
        ex_regwrite   = 1'b0;
        ex_write_num  = '0;
    endtask

    // Present one instruction, hold it while stalled, return at the negedge
    // after the accepting edge with the input bus idle.
    task automatic send(input logic [31:0] pc, input logic [DW-1:0] alu,
                        input logic [DW-1:0] sdata, input logic [1:0] jump,
                        input logic mtr, input logic mw, input logic rw,
                        input logic [4:0] wn);
        int n;
        ex_valid      = 1'b1;
        ex_pc         = pc;
        ex_alu        = alu;
        ex_store_data = sdata;
        ex_jump       = jump;
        ex_memtoreg   = mtr;
        ex_memwrite   = mw;
        ex_regwrite   = rw;
        ex_write_num  = wn;
        n = 0;
        while (mem_stall && n < 50) begin
            tick();
            n++;
        end
        check("send_accept", mem_stall, 1'b0);
        tick();
        drive_idle();
    endtask

    // Memory model: answers an outstanding request after mem_wait cycles.
    always @(negedge clk) begin
        resp_rvalid = 1'b0;
        if (resp_en && dm_req) begin
            if (wcnt == mem_wait) begin
                resp_rvalid = 1'b1;
                dm_rdata    = mem_rdata;
                wcnt        = 0;
            end else begin
                wcnt++;
            end
        end else begin
            wcnt = 0;
        end
    end

    // Writeback monitor against the expected queue.
    always @(negedge clk) begin
        if (mon_en && wb_valid) begin
            if (exp_q.size() == 0) begin
                check("wb_unexpected", 1'b1, 1'b0);
            end else begin
                check("wb_seq", {wb_pc, wb_alu, wb_jump, wb_mem}, exp_q.pop_front());
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        rst_n = 1'b0;
        drive_idle();
        repeat (2) @(negedge clk);

        // reset values
        check("rst_mem_stall", mem_stall, 1'b0);
        check("rst_dm_req", dm_req, 1'b0);
        check("rst_dm_we", dm_we, 1'b0);
        check("rst_dm_addr", dm_addr, 32'h0);
        check("rst_dm_wdata", dm_wdata, 32'h0);
        check("rst_wb", {wb_valid, wb_pc, wb_alu, wb_mem, wb_jump, wb_memtoreg, wb_regwrite, wb_write_num}, '0);
        rst_n = 1'b1;
        tick();

        // ALU op: one-cycle latency, never stalls
        send(32'h100, 32'h1234, 32'h0, 2'b00, 1'b0, 1'b0, 1'b1, 5'd5);
        check("alu_valid", wb_valid, 1'b1);
        check("alu_alu", wb_alu, 32'h1234);
        check("alu_mem", wb_mem, 32'h0);
        check("alu_pc", wb_pc, 32'h100);
        check("alu_rw", wb_regwrite, 1'b1);
        check("alu_wn", wb_write_num, 5'd5);
        check("alu_stall", mem_stall, 1'b0);
        tick();
        check("idle_valid", wb_valid, 1'b0);
        check("idle_rw", wb_regwrite, 1'b0);
        check("idle_alu_hold", wb_alu, 32'h1234);

        // Load, zero wait
        resp_en   = 1'b1;
        mem_wait  = 0;
        mem_rdata = 32'hDEADBEEF;
        send(32'h104, 32'h40, 32'h0, 2'b00, 1'b1, 1'b0, 1'b1, 5'd7);
        check("ld_req", dm_req, 1'b1);
        check("ld_we", dm_we, 1'b0);
        check("ld_addr", dm_addr, 32'h40);
        check("ld_stall", mem_stall, 1'b1);
        check("ld_wb_bubble", wb_valid, 1'b0);
        tick();
        check("ld_valid", wb_valid, 1'b1);
        check("ld_mem", wb_mem, 32'hDEADBEEF);
        check("ld_memtoreg", wb_memtoreg, 1'b1);
        check("ld_wn", wb_write_num, 5'd7);
        check("ld_pc", wb_pc, 32'h104);
        check("ld_stall_done", mem_stall, 1'b0);
        check("ld_req_done", dm_req, 1'b0);

        // Store, 3 wait cycles
        mem_wait  = 3;
        mem_rdata = 32'hFFFF0000;
        send(32'h108, 32'h10, 32'hA5A5, 2'b00, 1'b0, 1'b1, 1'b0, 5'd0);
        for (int i = 0; i < 4; i++) begin
            check("st_req", dm_req, 1'b1);
            check("st_we", dm_we, 1'b1);
            check("st_addr", dm_addr, 32'h10);
            check("st_wdata", dm_wdata, 32'hA5A5);
            check("st_stall", mem_stall, 1'b1);
            check("st_wb_bubble", wb_valid, 1'b0);
            tick();
        end
        check("st_valid", wb_valid, 1'b1);
        check("st_rw", wb_regwrite, 1'b0);
        check("st_mem_zero", wb_mem, 32'h0);
        check("st_stall_done", mem_stall, 1'b0);
        check("st_req_done", dm_req, 1'b0);
        tick();

        // jal -> load -> ALU: ordered, nothing lost or duplicated
        mem_wait  = 0;
        mem_rdata = 32'h12345678;
        exp_q.push_back({32'h200, 32'h201, 2'b10, 32'h0});
        exp_q.push_back({32'h201, 32'h80, 2'b00, 32'h12345678});
        exp_q.push_back({32'h202, 32'h55, 2'b00, 32'h0});
        mon_en = 1'b1;
        send(32'h200, 32'h201, 32'h0, 2'b10, 1'b0, 1'b0, 1'b1, 5'd31);
        check("jal_jump", wb_jump, 2'b10);
        send(32'h201, 32'h80, 32'h0, 2'b00, 1'b1, 1'b0, 1'b1, 5'd3);
        send(32'h202, 32'h55, 32'h0, 2'b00, 1'b0, 1'b0, 1'b1, 5'd4);
        repeat (2) tick();
        mon_en = 1'b0;
        check("seq_drained", exp_q.size(), 0);

        // Reset during ACCESS, late response afterwards
        resp_en = 1'b0;
        send(32'h400, 32'h33, 32'h0, 2'b00, 1'b1, 1'b0, 1'b1, 5'd9);
        check("rst_acc_req", dm_req, 1'b1);
        check("rst_acc_addr", dm_addr, 32'h33);
        repeat (2) tick();
        check("rst_acc_stall", mem_stall, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_stall", mem_stall, 1'b0);
        check("mid_rst_req", dm_req, 1'b0);
        check("mid_rst_addr", dm_addr, 32'h0);
        check("mid_rst_state", dut.state, 1'b0);
        check("mid_rst_wb", {wb_valid, wb_pc, wb_alu, wb_mem, wb_regwrite}, '0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        spur_rvalid = 1'b1;
        tick();
        spur_rvalid = 1'b0;
        check("late_rsp_valid", wb_valid, 1'b0);
        check("late_rsp_stall", mem_stall, 1'b0);
        tick();
        check("late_rsp_valid2", wb_valid, 1'b0);
        check("late_rsp_req", dm_req, 1'b0);

        // Spurious dm_rvalid in IDLE
        send(32'h300, 32'h77, 32'h0, 2'b00, 1'b0, 1'b0, 1'b1, 5'd2);
        tick();
        spur_rvalid = 1'b1;
        check("spur_req", dm_req, 1'b0);
        tick();
        spur_rvalid = 1'b0;
        check("spur_valid", wb_valid, 1'b0);
        check("spur_alu", wb_alu, 32'h77);
        check("spur_pc", wb_pc, 32'h300);
        check("spur_mem", wb_mem, 32'h0);
        check("spur_req2", dm_req, 1'b0);
        check("spur_stall", mem_stall, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
